// File: rtl/ctrl_multiciclo_if.sv
// Control bundle between the multicycle controller and the datapath:
// IR fields and ALU zero flag in, every datapath select/enable and debug state out.
interface ctrl_multiciclo_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg;
   logic       ALoad, BLoad, ALUOutLoad, MDRLoad;
   logic [1:0] AluSrcA;
   logic [1:0] AluSrcB;
   logic [2:0] AluOp;
   logic [1:0] PCSource;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero,
      output PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
      output ALoad, BLoad, ALUOutLoad, MDRLoad, AluSrcA, AluSrcB, AluOp, PCSource,
      output illegal, state
   );

   modport slave (
      output opcode, funct, zero,
      input  PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
      input  ALoad, BLoad, ALUOutLoad, MDRLoad, AluSrcA, AluSrcB, AluOp, PCSource,
      input  illegal, state
   );
endinterface

// File: rtl/ctrl_multiciclo.sv
// Multicycle Moore control FSM: fetch/decode/execute/memory/write-back sequencing.
// Outputs decode from the state register; funct only selects the ALU op while IR is held stable.
module ctrl_multiciclo (
   input  logic             clk,
   input  logic             reset,
   ctrl_multiciclo_if.master bus
);
   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_EXEC_SH   = 4'd4,
      S_WB_R      = 4'd5,
      S_EXEC_ADDI = 4'd6,
      S_WB_I      = 4'd7,
      S_MEM_ADDR  = 4'd8,
      S_MEM_RD    = 4'd9,
      S_MEM_WB    = 4'd10,
      S_MEM_WR    = 4'd11,
      S_BRANCH    = 4'd12,
      S_JUMP      = 4'd13,
      S_ILLEGAL   = 4'd14
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_RESET;
      else       state_q <= state_d;
   end

   assign bus.state = state_q;

   always_comb begin
      state_d         = S_RESET;
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.ALoad       = 1'b0;
      bus.BLoad       = 1'b0;
      bus.ALUOutLoad  = 1'b0;
      bus.MDRLoad     = 1'b0;
      bus.AluSrcA     = 2'b00;
      bus.AluSrcB     = 2'b00;
      bus.AluOp       = ALU_ADD;
      bus.PCSource    = 2'b00;
      bus.illegal     = 1'b0;

      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH: begin
            bus.IRWrite = 1'b1;
            bus.AluSrcB = 2'b01;
            bus.PCWrite = 1'b1;
            state_d     = S_DECODE;
         end
         S_DECODE: begin
            // Branch target is computed speculatively here while A/B load.
            bus.AluSrcB    = 2'b11;
            bus.ALUOutLoad = 1'b1;
            bus.ALoad      = 1'b1;
            bus.BLoad      = 1'b1;
            case (bus.opcode)
               6'h00: begin
                  case (bus.funct)
                     6'h20, 6'h22, 6'h24, 6'h25, 6'h2a: state_d = S_EXEC_R;
                     6'h00, 6'h02:                      state_d = S_EXEC_SH;
                     default:                           state_d = S_ILLEGAL;
                  endcase
               end
               6'h08:        state_d = S_EXEC_ADDI;
               6'h23, 6'h2b: state_d = S_MEM_ADDR;
               6'h04:        state_d = S_BRANCH;
               6'h02:        state_d = S_JUMP;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R: begin
            bus.AluSrcA    = 2'b01;
            bus.ALUOutLoad = 1'b1;
            case (bus.funct)
               6'h22:   bus.AluOp = ALU_SUB;
               6'h24:   bus.AluOp = ALU_AND;
               6'h25:   bus.AluOp = ALU_OR;
               6'h2a:   bus.AluOp = ALU_SLT;
               default: bus.AluOp = ALU_ADD;
            endcase
            state_d = S_WB_R;
         end
         S_EXEC_SH: begin
            bus.AluSrcA    = 2'b10;
            bus.ALUOutLoad = 1'b1;
            bus.AluOp      = (bus.funct == 6'h02) ? ALU_SRL : ALU_SLL;
            state_d        = S_WB_R;
         end
         S_WB_R: begin
            bus.RegDst   = 1'b1;
            bus.RegWrite = 1'b1;
            state_d      = S_FETCH;
         end
         S_EXEC_ADDI: begin
            bus.AluSrcA    = 2'b01;
            bus.AluSrcB    = 2'b10;
            bus.ALUOutLoad = 1'b1;
            state_d        = S_WB_I;
         end
         S_WB_I: begin
            bus.RegWrite = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEM_ADDR: begin
            bus.AluSrcA    = 2'b01;
            bus.AluSrcB    = 2'b10;
            bus.ALUOutLoad = 1'b1;
            state_d        = (bus.opcode == 6'h2b) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            bus.IorD    = 1'b1;
            bus.MDRLoad = 1'b1;
            state_d     = S_MEM_WB;
         end
         S_MEM_WB: begin
            bus.MemtoReg = 1'b1;
            bus.RegWrite = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEM_WR: begin
            bus.IorD     = 1'b1;
            bus.MemWrite = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            // The datapath ANDs PCWriteCond with zero, so zero is not consulted here.
            bus.AluSrcA     = 2'b01;
            bus.AluOp       = ALU_SUB;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            bus.PCSource = 2'b10;
            bus.PCWrite  = 1'b1;
            state_d      = S_FETCH;
         end
         S_ILLEGAL: begin
            bus.illegal = 1'b1;
            state_d     = S_FETCH;
         end
         default: state_d = S_RESET;
      endcase
   end
endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Bench for ctrl_multiciclo: per-instruction control-word timelines from an instruction-class model.
module tb_ctrl_multiciclo;
   logic clk;
   logic reset;
   ctrl_multiciclo_if bus ();

   ctrl_multiciclo dut (.clk(clk), .reset(reset), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_write, pc_write_cond, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
      logic       a_load, b_load, alu_out_load, mdr_load, illegal;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
   } ctl_t;

   typedef enum int {C_R, C_SH, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILL} cls_t;

   int checks = 0;
   int errors = 0;

   function automatic cls_t classify(input logic [5:0] opc, input logic [5:0] fn);
      if (opc == 6'h00) begin
         if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a}) return C_R;
         if (fn inside {6'h00, 6'h02}) return C_SH;
         return C_ILL;
      end
      if (opc == 6'h08) return C_ADDI;
      if (opc == 6'h23) return C_LW;
      if (opc == 6'h2b) return C_SW;
      if (opc == 6'h04) return C_BEQ;
      if (opc == 6'h02) return C_J;
      return C_ILL;
   endfunction

   function automatic int cpi(input cls_t c);
      case (c)
         C_LW:              return 5;
         C_BEQ, C_J, C_ILL: return 3;
         default:           return 4;
      endcase
   endfunction

   function automatic logic [2:0] r_op(input logic [5:0] fn);
      case (fn)
         6'h20:   return 3'd0;
         6'h22:   return 3'd1;
         6'h24:   return 3'd2;
         6'h25:   return 3'd3;
         6'h2a:   return 3'd4;
         6'h00:   return 3'd5;
         default: return 3'd6;
      endcase
   endfunction

   // Expected control word for cycle cyc (0 = fetch) of an instruction of class c.
   function automatic ctl_t expect_word(input cls_t c, input int cyc, input logic [5:0] fn);
      ctl_t e;
      e = '0;
      if (cyc == 0) begin
         e.ir_write = 1'b1; e.pc_write = 1'b1; e.src_b = 2'b01;
      end else if (cyc == 1) begin
         e.src_b = 2'b11; e.alu_out_load = 1'b1; e.a_load = 1'b1; e.b_load = 1'b1;
      end else if (cyc == 2) begin
         case (c)
            C_R:  begin e.src_a = 2'b01; e.alu_op = r_op(fn); e.alu_out_load = 1'b1; end
            C_SH: begin e.src_a = 2'b10; e.alu_op = r_op(fn); e.alu_out_load = 1'b1; end
            C_ADDI, C_LW, C_SW: begin e.src_a = 2'b01; e.src_b = 2'b10; e.alu_out_load = 1'b1; end
            C_BEQ: begin
               e.src_a = 2'b01; e.alu_op = 3'd1; e.pc_write_cond = 1'b1; e.pc_source = 2'b01;
            end
            C_J:     begin e.pc_source = 2'b10; e.pc_write = 1'b1; end
            default: e.illegal = 1'b1;
         endcase
      end else if (cyc == 3) begin
         case (c)
            C_R, C_SH: begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            C_ADDI:    e.reg_write = 1'b1;
            C_LW:      begin e.iord = 1'b1; e.mdr_load = 1'b1; end
            C_SW:      begin e.iord = 1'b1; e.mem_write = 1'b1; end
            default:   e = '0;
         endcase
      end else if (cyc == 4 && c == C_LW) begin
         e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
      end
      return e;
   endfunction

   function automatic ctl_t observed();
      ctl_t o;
      o.pc_write = bus.PCWrite;     o.pc_write_cond = bus.PCWriteCond; o.iord = bus.IorD;
      o.mem_write = bus.MemWrite;   o.ir_write = bus.IRWrite;          o.reg_write = bus.RegWrite;
      o.reg_dst = bus.RegDst;       o.mem_to_reg = bus.MemtoReg;       o.a_load = bus.ALoad;
      o.b_load = bus.BLoad;         o.alu_out_load = bus.ALUOutLoad;   o.mdr_load = bus.MDRLoad;
      o.illegal = bus.illegal;      o.src_a = bus.AluSrcA;             o.src_b = bus.AluSrcB;
      o.alu_op = bus.AluOp;         o.pc_source = bus.PCSource;
      return o;
   endfunction

   task automatic check(input ctl_t exp, input string tag);
      ctl_t obs;
      obs = observed();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Entered with the DUT in FETCH, sampled 1ns after the edge; leaves it at the next FETCH.
   task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input logic z);
      cls_t c;
      c = classify(opc, fn);
      bus.opcode = opc; bus.funct = fn; bus.zero = z;
      #1;
      for (int cyc = 0; cyc < cpi(c); cyc++) begin
         check(expect_word(c, cyc, fn), $sformatf("op%02h_fn%02h_%s_c%0d", opc, fn, c.name(), cyc));
         @(posedge clk); #1;
      end
   endtask

   logic [5:0] op_pool [8];
   logic [5:0] fn_pool [8];

   initial begin
      op_pool = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h3f};
      fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h11};
      reset = 1'b1;
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0;

      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check('0, $sformatf("reset_hold%0d", i));
      end
      reset = 1'b0;
      #1;
      check('0, "reset_state");
      @(posedge clk); #1;

      run_instr(6'h00, 6'h22, 1'b0);
      run_instr(6'h00, 6'h00, 1'b0);
      run_instr(6'h00, 6'h02, 1'b0);
      run_instr(6'h23, 6'h00, 1'b0);
      run_instr(6'h2b, 6'h00, 1'b0);
      run_instr(6'h04, 6'h00, 1'b1);
      run_instr(6'h04, 6'h00, 1'b0);
      run_instr(6'h3f, 6'h00, 1'b0);
      run_instr(6'h02, 6'h00, 1'b0);
      run_instr(6'h08, 6'h00, 1'b0);
      run_instr(6'h00, 6'h3c, 1'b0);

      // lw interrupted by reset in MEM_RD: write-back must never happen.
      bus.opcode = 6'h23; bus.funct = 6'h00;
      #1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         check(expect_word(C_LW, cyc, 6'h00), $sformatf("lw_abort_c%0d", cyc));
         if (cyc < 3) begin @(posedge clk); #1; end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      check('0, "reset_mid_lw");
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 60; i++) begin
         logic [5:0] opc, fn;
         opc = op_pool[$urandom_range(0, 7)];
         fn  = fn_pool[$urandom_range(0, 7)];
         if ($urandom_range(0, 9) == 0) opc = 6'($urandom);
         run_instr(opc, fn, 1'($urandom));
      end
      check(expect_word(C_R, 0, 6'h00), "final_fetch");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
